mem_stage: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline; consumes the EX/MEM register contents (result, dmem address/wdata, opsel, mem_read/mem_write, rd info) and acts as the data-memory initiator/responder bridge.
- Generates byte-lane masks and aligned store data, issues requests on a ready/valid data-memory bus, extracts and sign/zero-extends load data, and produces the MEM/WB register.
- Asserts o_stall back to IF/ID/EX while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : memory stage of the 5-stage RV32I pipeline.
//
// Takes the EX/MEM register contents and bridges them onto a ready/valid
// data-memory bus. Stores are lane-replicated with byte-lane masks; load words
// are reduced to the addressed byte/half and sign- or zero-extended. Produces
// the MEM/WB register and holds the upstream stages with o_stall while a
// memory transaction is outstanding.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_vld .. i_pc             EX/MEM entry (sampled only while idle)
//   o_dmem_req .. o_dmem_mask data-memory request (registered, held until ready)
//   i_dmem_ready              request accepted this cycle
//   i_dmem_rvld, i_dmem_rdata read response
//   o_stall                   hold IF/ID/EX
//   o_vld .. o_pc             MEM/WB register, o_vld is a one-cycle pulse
//   o_trap_misalign           misaligned/undefined access, coincident with o_vld
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [2:0]  i_opsel,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_pc,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvld,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_vld,
  output logic [31:0] o_res,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic [31:0] o_pc,
  output logic        o_trap_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // funct3 values 011, 110, 111 have no load/store meaning.
  function automatic logic opsel_legal(input logic [2:0] op);
    logic ok;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Undefined opsel is folded into the misaligned trap.
  function automatic logic access_bad(input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    case (op[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad | ~opsel_legal(op);
  endfunction

  // Byte-lane enables; loads always fetch the full word.
  function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] lo,
                                           input logic store);
    logic [3:0] m;
    if (store) begin
      case (op[1:0])
        2'b00:   m = 4'b0001 << lo;
        2'b01:   m = 4'b0011 << {lo[1], 1'b0};
        default: m = 4'b1111;
      endcase
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] d;
    case (op[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {lo, 3'b000};
    case (op)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'h00_0000, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'h0000, sh[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t      state_r, state_nxt_s;

  logic        stall_r,     stall_nxt_s;
  logic        req_r,       req_nxt_s;
  logic        wen_r,       wen_nxt_s;
  logic [31:0] addr_r,      addr_nxt_s;
  logic [31:0] wdata_r,     wdata_nxt_s;
  logic [3:0]  mask_r,      mask_nxt_s;
  logic        vld_r,       vld_nxt_s;
  logic [31:0] res_r,       res_nxt_s;
  logic [4:0]  rd_waddr_r,  rd_waddr_nxt_s;
  logic        rd_wen_r,    rd_wen_nxt_s;
  logic [31:0] pc_r,        pc_nxt_s;
  logic        trap_r,      trap_nxt_s;

  // Transaction context held across REQ/WAIT
  logic [2:0]  lat_op_r,    lat_op_nxt_s;
  logic [1:0]  lat_lo_r,    lat_lo_nxt_s;
  logic [4:0]  lat_rd_r,    lat_rd_nxt_s;
  logic        lat_wen_r,   lat_wen_nxt_s;
  logic [31:0] lat_pc_r,    lat_pc_nxt_s;
  logic        lat_store_r, lat_store_nxt_s;
  logic        lat_mreg_r,  lat_mreg_nxt_s;

  logic        mem_op_s;
  logic        bad_s;

  assign mem_op_s = i_mem_read | i_mem_write;
  assign bad_s    = access_bad(i_opsel, i_dmem_addr[1:0]);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_vld && mem_op_s && !bad_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_dmem_ready) begin
          state_nxt_s = lat_store_r ? ST_IDLE : ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (i_dmem_rvld) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of every registered output and the context
  always_comb begin
    stall_nxt_s     = (state_nxt_s != ST_IDLE);
    req_nxt_s       = req_r;
    wen_nxt_s       = wen_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    mask_nxt_s      = mask_r;
    vld_nxt_s       = 1'b0;
    res_nxt_s       = res_r;
    rd_waddr_nxt_s  = rd_waddr_r;
    rd_wen_nxt_s    = 1'b0;
    pc_nxt_s        = pc_r;
    trap_nxt_s      = 1'b0;
    lat_op_nxt_s    = lat_op_r;
    lat_lo_nxt_s    = lat_lo_r;
    lat_rd_nxt_s    = lat_rd_r;
    lat_wen_nxt_s   = lat_wen_r;
    lat_pc_nxt_s    = lat_pc_r;
    lat_store_nxt_s = lat_store_r;
    lat_mreg_nxt_s  = lat_mreg_r;
    case (state_r)
      ST_IDLE: begin
        if (i_vld && !mem_op_s) begin
          res_nxt_s      = i_res;
          rd_waddr_nxt_s = i_rd_waddr;
          rd_wen_nxt_s   = i_rd_wen;
          pc_nxt_s       = i_pc;
          vld_nxt_s      = 1'b1;
        end else if (i_vld && bad_s) begin
          // Trap retires without a bus request and without writeback
          res_nxt_s      = i_res;
          rd_waddr_nxt_s = i_rd_waddr;
          pc_nxt_s       = i_pc;
          vld_nxt_s      = 1'b1;
          trap_nxt_s     = 1'b1;
        end else if (i_vld) begin
          lat_op_nxt_s    = i_opsel;
          lat_lo_nxt_s    = i_dmem_addr[1:0];
          lat_rd_nxt_s    = i_rd_waddr;
          lat_wen_nxt_s   = i_rd_wen;
          lat_pc_nxt_s    = i_pc;
          lat_store_nxt_s = i_mem_write;
          lat_mreg_nxt_s  = i_mem_reg;
          res_nxt_s       = i_res;
          req_nxt_s       = 1'b1;
          wen_nxt_s       = i_mem_write;
          addr_nxt_s      = {i_dmem_addr[31:2], 2'b00};
          mask_nxt_s      = lane_mask(i_opsel, i_dmem_addr[1:0], i_mem_write);
          wdata_nxt_s     = lane_data(i_opsel, i_dmem_wdata);
        end else begin
          vld_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_dmem_ready) begin
          req_nxt_s = 1'b0;
          if (lat_store_r) begin
            vld_nxt_s      = 1'b1;
            rd_waddr_nxt_s = lat_rd_r;
            pc_nxt_s       = lat_pc_r;
          end else begin
            vld_nxt_s = 1'b0;
          end
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_dmem_rvld) begin
          res_nxt_s      = lat_mreg_r ? load_extend(lat_op_r, lat_lo_r, i_dmem_rdata) : res_r;
          rd_waddr_nxt_s = lat_rd_r;
          rd_wen_nxt_s   = lat_wen_r;
          pc_nxt_s       = lat_pc_r;
          vld_nxt_s      = 1'b1;
        end else begin
          vld_nxt_s = 1'b0;
        end
      end
      default: begin
        req_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and transaction context
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_r     <= 1'b0;
      req_r       <= 1'b0;
      wen_r       <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      mask_r      <= 4'b0000;
      vld_r       <= 1'b0;
      res_r       <= 32'h0000_0000;
      rd_waddr_r  <= 5'd0;
      rd_wen_r    <= 1'b0;
      pc_r        <= RESET_PC;
      trap_r      <= 1'b0;
      lat_op_r    <= 3'b000;
      lat_lo_r    <= 2'b00;
      lat_rd_r    <= 5'd0;
      lat_wen_r   <= 1'b0;
      lat_pc_r    <= 32'h0000_0000;
      lat_store_r <= 1'b0;
      lat_mreg_r  <= 1'b0;
    end else begin
      stall_r     <= stall_nxt_s;
      req_r       <= req_nxt_s;
      wen_r       <= wen_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      mask_r      <= mask_nxt_s;
      vld_r       <= vld_nxt_s;
      res_r       <= res_nxt_s;
      rd_waddr_r  <= rd_waddr_nxt_s;
      rd_wen_r    <= rd_wen_nxt_s;
      pc_r        <= pc_nxt_s;
      trap_r      <= trap_nxt_s;
      lat_op_r    <= lat_op_nxt_s;
      lat_lo_r    <= lat_lo_nxt_s;
      lat_rd_r    <= lat_rd_nxt_s;
      lat_wen_r   <= lat_wen_nxt_s;
      lat_pc_r    <= lat_pc_nxt_s;
      lat_store_r <= lat_store_nxt_s;
      lat_mreg_r  <= lat_mreg_nxt_s;
    end
  end

  assign o_stall         = stall_r;
  assign o_dmem_req      = req_r;
  assign o_dmem_wen      = wen_r;
  assign o_dmem_addr     = addr_r;
  assign o_dmem_wdata    = wdata_r;
  assign o_dmem_mask     = mask_r;
  assign o_vld           = vld_r;
  assign o_res           = res_r;
  assign o_rd_waddr      = rd_waddr_r;
  assign o_rd_wen        = rd_wen_r;
  assign o_pc            = pc_r;
  assign o_trap_misalign = trap_r;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage : self-checking bench for mem_stage. Directed cases plus
// randomized loads/stores/ALU ops with random bus handshake delays, checked
// against an arithmetic reference model of the memory stage.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        i_clk, i_rst_n, i_vld, i_mem_read, i_mem_write, i_mem_reg, i_rd_wen;
  logic [31:0] i_res, i_dmem_addr, i_dmem_wdata, i_pc, i_dmem_rdata;
  logic [2:0]  i_opsel;
  logic [4:0]  i_rd_waddr;
  logic        i_dmem_ready, i_dmem_rvld;
  logic        o_dmem_req, o_dmem_wen, o_stall, o_vld, o_rd_wen, o_trap_misalign;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_res, o_pc;
  logic [3:0]  o_dmem_mask;
  logic [4:0]  o_rd_waddr;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  mem_stage #(.RESET_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_res(i_res),
    .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata), .i_opsel(i_opsel),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_reg(i_mem_reg),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_pc(i_pc),
    .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_vld(o_vld), .o_res(o_res), .o_rd_waddr(o_rd_waddr),
    .o_rd_wen(o_rd_wen), .o_pc(o_pc), .o_trap_misalign(o_trap_misalign)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned access_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_trap(input logic [2:0] op, input logic [31:0] a);
    int unsigned sz = access_size(op);
    return (sz == 0) || ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] model_mask(input bit st, input logic [2:0] op, input logic [31:0] a);
    int unsigned sz = access_size(op);
    if (!st || sz == 4) return 4'hF;
    if (sz == 1) return 4'h1 << (a % 32'd4);
    return 4'h3 << (a % 32'd4);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
    int unsigned sz = access_size(op);
    if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int unsigned sz  = access_size(op);
    bit          sgn = (op == 3'd0) || (op == 3'd1);
    logic [31:0] v   = rd >> (32'd8 * (a % 32'd4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    if (o_stall) stall_cnt++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_cycle();
    i_vld = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check_value("idle_vld",   o_vld, 0);
    check_value("idle_trap",  o_trap_misalign, 0);
    check_value("idle_stall", o_stall, 0);
    check_value("idle_req",   o_dmem_req, 0);
  endtask

  // One EX/MEM entry from issue to retirement; called at a negedge with o_stall=0.
  task automatic run_instr(input bit rd_op, input bit wr_op, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] res, input logic [4:0] rd, input bit rwen,
                           input logic [31:0] pc, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rdata);
    logic [3:0]  e_mask;
    logic [31:0] e_wdata, e_addr;
    int          e_stall;
    i_vld = 1'b1; i_mem_read = rd_op; i_mem_write = wr_op; i_mem_reg = rd_op;
    i_opsel = op; i_dmem_addr = addr; i_dmem_wdata = wdata; i_res = res;
    i_rd_waddr = rd; i_rd_wen = rwen; i_pc = pc;
    i_dmem_ready = 1'b0; i_dmem_rvld = 1'b0;
    stall_cnt = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    if (!(rd_op || wr_op)) begin
      check_value("alu_vld",   o_vld, 1);
      check_value("alu_res",   o_res, res);
      check_value("alu_rd",    o_rd_waddr, rd);
      check_value("alu_wen",   o_rd_wen, rwen);
      check_value("alu_pc",    o_pc, pc);
      check_value("alu_stall", o_stall, 0);
      check_value("alu_trap",  o_trap_misalign, 0);
    end else if (model_trap(op, addr)) begin
      check_value("trap_vld",   o_vld, 1);
      check_value("trap_flag",  o_trap_misalign, 1);
      check_value("trap_wen",   o_rd_wen, 0);
      check_value("trap_req",   o_dmem_req, 0);
      check_value("trap_stall", o_stall, 0);
      check_value("trap_pc",    o_pc, pc);
    end else begin
      e_mask  = model_mask(wr_op, op, addr);
      e_wdata = wr_op ? model_wdata(op, wdata) : o_dmem_wdata;
      e_addr  = addr - (addr % 32'd4);
      check_value("req_vld",   o_vld, 0);
      check_value("req_wen",   o_dmem_wen, wr_op);
      check_value("req_req",   o_dmem_req, 1);
      check_value("req_addr",  o_dmem_addr, e_addr);
      check_value("req_mask",  o_dmem_mask, e_mask);
      if (wr_op) check_value("req_wdata", o_dmem_wdata, e_wdata);
      i_vld = 1'b0;
      for (int k = 0; k < rdy_dly; k++) begin
        i_dmem_ready = 1'b0;
        i_dmem_rvld  = 1'($urandom_range(0, 1));
        i_dmem_rdata = $urandom;
        tick();
        check_value("hold_req",  o_dmem_req, 1);
        check_value("hold_addr", o_dmem_addr, e_addr);
        check_value("hold_mask", o_dmem_mask, e_mask);
        if (wr_op) check_value("hold_wdata", o_dmem_wdata, e_wdata);
        check_value("hold_vld",  o_vld, 0);
      end
      i_dmem_ready = 1'b1;
      i_dmem_rvld  = 1'b0;
      tick();
      i_dmem_ready = 1'b0;
      check_value("acc_req", o_dmem_req, 0);
      if (wr_op) begin
        e_stall = rdy_dly + 1;
        check_value("st_vld",   o_vld, 1);
        check_value("st_wen",   o_rd_wen, 0);
        check_value("st_trap",  o_trap_misalign, 0);
        check_value("st_pc",    o_pc, pc);
      end else begin
        e_stall = rdy_dly + rv_dly + 2;
        check_value("ld_wait_vld", o_vld, 0);
        for (int j = 0; j < rv_dly; j++) begin
          tick();
          check_value("ld_wait_vld", o_vld, 0);
        end
        i_dmem_rvld  = 1'b1;
        i_dmem_rdata = rdata;
        tick();
        i_dmem_rvld  = 1'b0;
        check_value("ld_vld",  o_vld, 1);
        check_value("ld_res",  o_res, model_load(op, addr, rdata));
        check_value("ld_wen",  o_rd_wen, rwen);
        check_value("ld_rd",   o_rd_waddr, rd);
        check_value("ld_pc",   o_pc, pc);
        check_value("ld_trap", o_trap_misalign, 0);
      end
      check_value("end_stall",    o_stall, 0);
      check_value("stall_cycles", stall_cnt, e_stall);
    end
    i_vld = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    int          kind;
    i_rst_n = 1'b0; i_vld = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_reg = 1'b0;
    i_res = 32'h0; i_dmem_addr = 32'h0; i_dmem_wdata = 32'h0; i_pc = 32'h0;
    i_opsel = 3'd0; i_rd_waddr = 5'd0; i_rd_wen = 1'b0;
    i_dmem_ready = 1'b0; i_dmem_rvld = 1'b0; i_dmem_rdata = 32'h0;
    repeat (2) @(negedge i_clk);
    check_value("rst_req",   o_dmem_req, 0);
    check_value("rst_mask",  o_dmem_mask, 0);
    check_value("rst_stall", o_stall, 0);
    check_value("rst_vld",   o_vld, 0);
    check_value("rst_res",   o_res, 0);
    check_value("rst_pc",    o_pc, RST_PC);
    i_rst_n = 1'b1;
    idle_cycle();

    // Directed cases
    run_instr(0, 0, 3'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1, 32'h40, 0, 0, 32'h0);
    run_instr(0, 1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 5'd3, 1, 32'h44, 3, 0, 32'h0);
    run_instr(1, 0, 3'd0, 32'h0000_2002, 32'h0, 32'h0, 5'd7, 1, 32'h48, 0, 0, 32'h0080_0000);
    run_instr(1, 0, 3'd4, 32'h0000_2002, 32'h0, 32'h0, 5'd7, 1, 32'h4C, 1, 1, 32'h0080_0000);
    run_instr(1, 0, 3'd1, 32'h0000_2002, 32'h0, 32'h0, 5'd8, 1, 32'h50, 0, 2, 32'h8001_0000);
    run_instr(1, 0, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 5'd9, 1, 32'h54, 0, 0, 32'h0);
    idle_cycle();
    run_instr(1, 0, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 5'd10, 1, 32'h58, 0, 0, 32'hDEAD_BEEF);
    run_instr(1, 0, 3'd6, 32'h0000_0100, 32'h0, 32'h0, 5'd11, 1, 32'h5C, 0, 0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        op = ($urandom_range(0, 2) == 0) ? 3'd3 : ($urandom_range(0, 1) == 0 ? 3'd6 : 3'd7);
      end else if (kind == 2) begin
        op = 3'($urandom_range(0, 2));
      end else begin
        op = 3'($urandom_range(0, 4));
        if (op == 3'd3) op = 3'd4;
        if (op == 3'd4 && $urandom_range(0, 1) == 1) op = 3'd5;
      end
      if ($urandom_range(0, 2) != 0) a = a & ~((access_size(op) == 0) ? 32'd0 : access_size(op) - 32'd1);
      run_instr(kind == 1, kind == 2, op, a, $urandom, $urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // Reset while a load waits for read data
    i_vld = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_reg = 1'b1;
    i_opsel = 3'd2; i_dmem_addr = 32'h0000_0200; i_rd_waddr = 5'd4; i_rd_wen = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_vld = 1'b0; i_dmem_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_dmem_ready = 1'b0;
    check_value("wait_stall", o_stall, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_value("mrst_stall", o_stall, 0);
    check_value("mrst_vld",   o_vld, 0);
    check_value("mrst_req",   o_dmem_req, 0);
    check_value("mrst_wen",   o_rd_wen, 0);
    check_value("mrst_res",   o_res, 0);
    check_value("mrst_addr",  o_dmem_addr, 0);
    check_value("mrst_pc",    o_pc, RST_PC);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_dmem_rvld = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    @(posedge i_clk); @(negedge i_clk);
    i_dmem_rvld = 1'b0;
    check_value("late_rvld_vld",   o_vld, 0);
    check_value("late_rvld_stall", o_stall, 0);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
